// File: rtl/alarm_buzzer_cntr.sv
// alarm_buzzer_cntr
//   Alarm stage behind the countdown timer. An alarm_start pulse launches a
//   finite train of beeps on buzz_clk. Each beep is a square-wave tone for
//   BEEP_ON_CYC cycles followed by BEEP_OFF_CYC cycles of silence. An
//   alarm_stop pulse silences the alarm at once.
//
// Ports
//   clk          in   system clock
//   reset_p      in   synchronous active-high reset
//   alarm_start  in   one-cycle pulse: timer expired (retriggers if active)
//   alarm_stop   in   one-cycle pulse: user acknowledge (wins over start)
//   buzz_clk     out  gated tone to the piezo, 0 whenever silent
//   alarm_active out  1 while a beep train is running
//   beep_cnt     out  completed beeps in the current alarm
//   alarm_done   out  one-cycle pulse on normal completion
//
// Parameters
//   TONE_HALF     clk cycles per tone half-period (>= 1)
//   BEEP_ON_CYC   clk cycles per beep (>= 1)
//   BEEP_OFF_CYC  clk cycles per silent gap (>= 1)
//   BEEP_NUM      beeps per alarm, 0 = repeat until stopped (0..15)
module alarm_buzzer_cntr #(
  parameter int unsigned TONE_HALF    = 25000,
  parameter int unsigned BEEP_ON_CYC  = 20000000,
  parameter int unsigned BEEP_OFF_CYC = 30000000,
  parameter int unsigned BEEP_NUM     = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       alarm_start,
  input  logic       alarm_stop,
  output logic       buzz_clk,
  output logic       alarm_active,
  output logic [3:0] beep_cnt,
  output logic       alarm_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2
  } state_e;

  localparam logic [31:0] TONE_LAST = 32'(TONE_HALF - 1);
  localparam logic [31:0] ON_LAST   = 32'(BEEP_ON_CYC - 1);
  localparam logic [31:0] OFF_LAST  = 32'(BEEP_OFF_CYC - 1);
  localparam logic [3:0]  BEEP_LIM  = 4'(BEEP_NUM);
  localparam logic        BEEP_FIN  = (BEEP_NUM != 0);

  state_e      state_q, state_d;
  logic [31:0] tone_q, tone_d;
  logic [31:0] ivl_q, ivl_d;
  logic        buzz_q, buzz_d;
  logic        active_q, active_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    ivl_d   = ivl_q;
    buzz_d  = buzz_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    // Stop outranks start, and start outranks every in-state transition,
    // so a retrigger on the completing edge suppresses the done pulse.
    if (alarm_stop) begin
      state_d = IDLE;
      buzz_d  = 1'b0;
      tone_d  = '0;
      ivl_d   = '0;
    end else if (alarm_start) begin
      state_d = BEEP_ON;
      buzz_d  = 1'b1;
      tone_d  = '0;
      ivl_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          buzz_d = 1'b0;
        end
        BEEP_ON: begin
          if (ivl_q == ON_LAST) begin
            state_d = BEEP_OFF;
            buzz_d  = 1'b0;
            ivl_d   = '0;
            tone_d  = '0;
          end else begin
            ivl_d = ivl_q + 32'd1;
            if (tone_q == TONE_LAST) begin
              tone_d = '0;
              buzz_d = ~buzz_q;
            end else begin
              tone_d = tone_q + 32'd1;
            end
          end
        end
        BEEP_OFF: begin
          buzz_d = 1'b0;
          if (ivl_q == OFF_LAST) begin
            ivl_d = '0;
            cnt_d = cnt_q + 4'd1;
            if (BEEP_FIN && (cnt_d == BEEP_LIM)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = BEEP_ON;
              buzz_d  = 1'b1;
              tone_d  = '0;
            end
          end else begin
            ivl_d = ivl_q + 32'd1;
          end
        end
        default: begin
          state_d = IDLE;
          buzz_d  = 1'b0;
          tone_d  = '0;
          ivl_d   = '0;
        end
      endcase
    end

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= IDLE;
      tone_q   <= '0;
      ivl_q    <= '0;
      buzz_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tone_q   <= tone_d;
      ivl_q    <= ivl_d;
      buzz_q   <= buzz_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign buzz_clk     = buzz_q;
  assign alarm_active = active_q;
  assign beep_cnt     = cnt_q;
  assign alarm_done   = done_q;

endmodule

// File: tb/tb_alarm_buzzer_cntr.sv
// Bench for alarm_buzzer_cntr. Two instances share the same stimulus:
// index 0 runs BEEP_NUM = 3 and index 1 runs BEEP_NUM = 0 (endless). A
// time-since-start model predicts the outputs of both on every cycle. Directed
// scenarios add literal expectations on top of that model.
module tb_alarm_buzzer_cntr;

  localparam int TH   = 2;
  localparam int ON   = 8;
  localparam int OFF  = 4;
  localparam int PER  = ON + OFF;
  localparam int BN_A = 3;

  logic       clk = 1'b0;
  logic       reset_p = 1'b0;
  logic       alarm_start = 1'b0;
  logic       alarm_stop = 1'b0;
  logic [1:0] buzz_w, act_w, done_w;
  logic [3:0] cnt_w [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alarm_buzzer_cntr #(
    .TONE_HALF(TH), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .BEEP_NUM(BN_A)
  ) dut (
    .clk(clk), .reset_p(reset_p), .alarm_start(alarm_start), .alarm_stop(alarm_stop),
    .buzz_clk(buzz_w[0]), .alarm_active(act_w[0]), .beep_cnt(cnt_w[0]),
    .alarm_done(done_w[0])
  );

  alarm_buzzer_cntr #(
    .TONE_HALF(TH), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .BEEP_NUM(0)
  ) dut0 (
    .clk(clk), .reset_p(reset_p), .alarm_start(alarm_start), .alarm_stop(alarm_stop),
    .buzz_clk(buzz_w[1]), .alarm_active(act_w[1]), .beep_cnt(cnt_w[1]),
    .alarm_done(done_w[1])
  );

  // Model: t counts cycles since the last start; position within a beep
  // period gives the tone, and every full period completes one beep.
  int m_bn  [2] = '{BN_A, 0};
  bit m_act [2];
  int m_t   [2];
  int m_cnt [2];
  bit m_done[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (reset_p) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_cnt[i] = 0;
      end else if (alarm_stop) begin
        m_act[i] = 1'b0;
      end else if (alarm_start) begin
        m_act[i] = 1'b1; m_t[i] = 0; m_cnt[i] = 0;
      end else if (m_act[i]) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] % PER == 0) begin
          m_cnt[i] = (m_cnt[i] + 1) % 16;
          if (m_bn[i] != 0 && m_cnt[i] == m_bn[i]) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  function automatic int exp_buzz(int i);
    int p;
    p = m_t[i] % PER;
    return (m_act[i] && p < ON && ((p / TH) % 2 == 0)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_buzz[%0d]", i), int'(buzz_w[i]), exp_buzz(i));
        check($sformatf("model_active[%0d]", i), int'(act_w[i]), int'(m_act[i]));
        check($sformatf("model_cnt[%0d]", i), int'(cnt_w[i]), m_cnt[i]);
        check($sformatf("model_done[%0d]", i), int'(done_w[i]), int'(m_done[i]));
      end
    end
  end

  // Apply inputs for one edge, return at the following negedge.
  task automatic step(input bit r, input bit s, input bit p);
    reset_p = r; alarm_start = s; alarm_stop = p;
    @(negedge clk);
    reset_p = 1'b0; alarm_start = 1'b0; alarm_stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Counts cycles with alarm_active high on instance 0, bounded.
  task automatic count_active(output int n);
    n = 0;
    while (act_w[0] && n < 100) begin
      n++;
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  logic exp_seq [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int n;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("rst_buzz", int'(buzz_w[0]), 0);
    check("rst_active", int'(act_w[0]), 0);
    check("rst_cnt", int'(cnt_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);

    // 1: first beep waveform
    step(1'b0, 1'b1, 1'b0);
    check("s1_active", int'(act_w[0]), 1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("s1_buzz_c%0d", i + 1), int'(buzz_w[0]), int'(exp_seq[i]));
      step(1'b0, 1'b0, 1'b0);
    end
    check("s1_cnt_after_beep", int'(cnt_w[0]), 1);

    // 2: full run from a fresh start
    step(1'b0, 1'b1, 1'b0);
    count_active(n);
    check("s2_active_cycles", n, 36);
    check("s2_done_pulse", int'(done_w[0]), 1);
    check("s2_final_cnt", int'(cnt_w[0]), 3);
    check("s2_final_buzz", int'(buzz_w[0]), 0);
    step(1'b0, 1'b0, 1'b0);
    check("s2_done_single", int'(done_w[0]), 0);
    check("s2_cnt_hold", int'(cnt_w[0]), 3);

    // 3: stop at cycle 5 of beep 2
    step(1'b0, 1'b1, 1'b0);
    idle(16);
    step(1'b0, 1'b0, 1'b1);
    check("s3_active", int'(act_w[0]), 0);
    check("s3_buzz", int'(buzz_w[0]), 0);
    check("s3_cnt", int'(cnt_w[0]), 1);
    check("s3_done", int'(done_w[0]), 0);

    // 4: retrigger during gap of beep 1
    step(1'b0, 1'b1, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 1'b0);
    check("s4_buzz", int'(buzz_w[0]), 1);
    check("s4_cnt", int'(cnt_w[0]), 0);
    count_active(n);
    check("s4_active_cycles", n, 36);

    // 5: start+stop together, active then idle
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b1);
    check("s5_active_busy", int'(act_w[0]), 0);
    check("s5_buzz_busy", int'(buzz_w[0]), 0);
    step(1'b0, 1'b1, 1'b1);
    check("s5_active_idle", int'(act_w[0]), 0);
    check("s5_buzz_idle", int'(buzz_w[0]), 0);

    // 6: reset mid-beep
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    check("s6_buzz", int'(buzz_w[0]), 0);
    check("s6_active", int'(act_w[0]), 0);
    check("s6_cnt", int'(cnt_w[0]), 0);
    check("s6_done", int'(done_w[0]), 0);

    // Endless variant: count wraps after 16 beeps
    step(1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 200; j++) begin
      step(1'b0, 1'b0, 1'b0);
      if (j == 180) check("bn0_cnt15", int'(cnt_w[1]), 15);
      if (j == 192) check("bn0_cnt_wrap", int'(cnt_w[1]), 0);
    end
    check("bn0_still_active", int'(act_w[1]), 1);
    check("bn0_no_done", int'(done_w[1]), 0);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_cntr.md
Name: alarm_buzzer_cntr

Overview:
Downstream alarm stage for the timer. It consumes the timer's one-cycle "time expired" pulse and a user stop pulse from a button edge detector. It produces a gated square-wave tone on buzz_clk as a finite train of beeps (tone on, silence, repeat), and reports its status to the mode/LED logic at the top level.

Parameters:
TONE_HALF, 25000, clk cycles per half-period of the tone (100 MHz clock gives 2 kHz)
BEEP_ON_CYC, 20000000, clk cycles per beep "on" interval (200 ms)
BEEP_OFF_CYC, 30000000, clk cycles per silent gap (300 ms)
BEEP_NUM, 10, beeps per alarm; 0 = repeat until stopped; legal range 0..15

Ports:
clk  in  1  system clock
reset_p  in  1  synchronous active-high reset
alarm_start  in  1  one-cycle pulse: timer reached zero
alarm_stop  in  1  one-cycle pulse: user acknowledge (button edge)
buzz_clk  out  1  tone output to piezo; 0 whenever silent
alarm_active  out  1  1 while not in IDLE
beep_cnt  out  4  number of completed beeps in the current alarm
alarm_done  out  1  one-cycle pulse on normal completion

Behaviour:
- Interface: one clock, clk. reset_p is synchronous and active-high. All outputs are registered.
- Reset, sampled at the clk edge:
  - state = IDLE
  - buzz_clk = 0, alarm_active = 0, beep_cnt = 0, alarm_done = 0
  - all internal counters = 0
  - reset_p overrides every other input and takes effect mid-beep.
- FSM states: IDLE, BEEP_ON, BEEP_OFF.
- IDLE:
  - Outputs: buzz_clk = 0, alarm_active = 0.
  - alarm_start = 1 at edge k gives, after edge k: state = BEEP_ON, buzz_clk = 1, alarm_active = 1, beep_cnt = 0, tone counter and interval counter cleared.
  - Latency from alarm_start to audible output: 1 cycle.
- BEEP_ON:
  - Lasts exactly BEEP_ON_CYC cycles.
  - buzz_clk toggles every TONE_HALF cycles, starting high. Example with TONE_HALF = 2: 1,1,0,0,1,1,...
  - After the last cycle, the next state is BEEP_OFF, with buzz_clk = 0 in the same cycle.
- BEEP_OFF:
  - Lasts exactly BEEP_OFF_CYC cycles; buzz_clk = 0 throughout.
  - After the last cycle, beep_cnt increments. Then:
    - If BEEP_NUM != 0 and the new count equals BEEP_NUM: go to IDLE, alarm_done = 1 for one cycle, beep_cnt holds its final value until the next start or reset.
    - Otherwise: go to BEEP_ON, with the tone counter restarted and buzz_clk = 1.
- BEEP_NUM = 0: beeps repeat forever; beep_cnt wraps 15 to 0.
- alarm_stop in BEEP_ON or BEEP_OFF:
  - Next cycle: state = IDLE, buzz_clk = 0, alarm_active = 0, beep_cnt holds.
  - alarm_done is not asserted.
- alarm_stop in IDLE: no effect.
- alarm_start while BEEP_ON or BEEP_OFF: retrigger. Sequence restarts exactly as from IDLE (BEEP_ON, beep_cnt = 0, counters cleared).
- alarm_start and alarm_stop in the same cycle: stop wins in every state, including IDLE.
- Boundary cases:
  - alarm_start on the same edge as normal completion: retrigger wins; alarm_done stays 0.
  - Stop on the same edge as completion: stop wins; no done pulse.
- Counters: internal interval and tone counters are 32 bits, count 0..N-1, and compare at N-1. Parameters must be at least 1 (except BEEP_NUM).

Test Plan:
All scenarios use TONE_HALF = 2, BEEP_ON_CYC = 8, BEEP_OFF_CYC = 4, BEEP_NUM = 3.
1. Reset, then pulse alarm_start.
   -> Next cycle: alarm_active = 1, buzz_clk = 1.
   -> buzz_clk sequence for 12 cycles: 1,1,0,0,1,1,0,0,0,0,0,0.
   -> beep_cnt becomes 1 after cycle 12.
2. Full run.
   -> Exactly 36 cycles active.
   -> alarm_done pulses once as alarm_active drops.
   -> beep_cnt = 3, buzz_clk = 0 afterwards.
3. alarm_stop at cycle 5 of beep 2.
   -> Next cycle: IDLE, buzz_clk = 0, beep_cnt = 1, no alarm_done.
4. alarm_start again at cycle 3 of BEEP_OFF of beep 1.
   -> Restart: buzz_clk = 1, beep_cnt = 0, then a full 36-cycle sequence.
5. Simultaneous start and stop while active, and again while IDLE.
   -> Block is in IDLE with buzz_clk = 0 in both cases.
6. reset_p asserted for one cycle mid-BEEP_ON.
   -> All outputs 0 on the next cycle.
   -> BEEP_NUM = 0 variant: still active after 200 cycles, and beep_cnt wraps 15 to 0 after 16 beeps.
